// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and optional operand forwarding (FWD_EN).
// Latency: one cycle from id_* to the EX outputs; stall and the forwarding muxes are combinational.
// Backpressure: stall holds upstream PC and IF/ID, and this stage loads a bubble while stall or flush is high.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_wreg,
  input  logic [31:0] id_rdata_a,
  input  logic [31:0] id_rdata_b,
  input  logic [31:0] id_imm,
  input  logic [2:0]  id_alu_ctrl,
  input  logic        id_alu_src,
  input  logic [3:0]  id_ctrl,
  input  logic        exmem_reg_write,
  input  logic [4:0]  exmem_wreg,
  input  logic [31:0] exmem_result,
  input  logic        memwb_reg_write,
  input  logic [4:0]  memwb_wreg,
  input  logic [31:0] memwb_result,
  output logic [31:0] BussA,
  output logic [31:0] BussB,
  output logic [2:0]  ALUControl,
  output logic [31:0] ex_store_data,
  output logic [4:0]  ex_wreg,
  output logic [3:0]  ex_ctrl,
  output logic        stall
);

  // id_ctrl / ex_ctrl bit order: {reg_write, mem_read, mem_write, mem_to_reg}
  localparam int CTRL_MEM_READ = 2;

  logic [4:0]  ex_rs;
  logic [4:0]  ex_rt;
  logic [31:0] ex_rdata_a;
  logic [31:0] ex_rdata_b;
  logic [31:0] ex_imm;
  logic        ex_alu_src;
  logic [31:0] opnd_a;
  logic [31:0] opnd_b;

  // Load-use hazard: the load now in EX writes a register the decode instruction reads.
  always_comb begin
    stall = 1'b0;
    if (ex_ctrl[CTRL_MEM_READ] && (ex_wreg != 5'd0) &&
        ((ex_wreg == id_rs) || (ex_wreg == id_rt)))
      stall = 1'b1;
  end

  // Pipeline register: reset, stall and flush all load the all-zero bubble.
  always_ff @(posedge clk) begin
    if (rst || flush || stall) begin
      ex_rs      <= 5'd0;
      ex_rt      <= 5'd0;
      ex_wreg    <= 5'd0;
      ex_rdata_a <= 32'd0;
      ex_rdata_b <= 32'd0;
      ex_imm     <= 32'd0;
      ALUControl <= 3'b000;
      ex_alu_src <= 1'b0;
      ex_ctrl    <= 4'b0000;
    end else begin
      ex_rs      <= id_rs;
      ex_rt      <= id_rt;
      ex_wreg    <= id_wreg;
      ex_rdata_a <= id_rdata_a;
      ex_rdata_b <= id_rdata_b;
      ex_imm     <= id_imm;
      ALUControl <= id_alu_ctrl;
      ex_alu_src <= id_alu_src;
      ex_ctrl    <= id_ctrl;
    end
  end

`ifdef FWD_EN
  // Forwarding muxes: the younger EX/MEM result wins over MEM/WB; register 0 is never forwarded.
  always_comb begin
    opnd_a = ex_rdata_a;
    opnd_b = ex_rdata_b;
    if (exmem_reg_write && (exmem_wreg != 5'd0) && (exmem_wreg == ex_rs))
      opnd_a = exmem_result;
    else if (memwb_reg_write && (memwb_wreg != 5'd0) && (memwb_wreg == ex_rs))
      opnd_a = memwb_result;
    if (exmem_reg_write && (exmem_wreg != 5'd0) && (exmem_wreg == ex_rt))
      opnd_b = exmem_result;
    else if (memwb_reg_write && (memwb_wreg != 5'd0) && (memwb_wreg == ex_rt))
      opnd_b = memwb_result;
  end
`else
  // Without forwarding the operands come straight from the registered read data.
  always_comb begin
    opnd_a = ex_rdata_a;
    opnd_b = ex_rdata_b;
  end

  // Writeback candidates and source numbers have no consumer in this build.
  logic unused_fwd;
  assign unused_fwd = ^{exmem_reg_write, exmem_wreg, exmem_result,
                        memwb_reg_write, memwb_wreg, memwb_result, ex_rs, ex_rt};
`endif

  // Operand B picks the immediate for I-type ops; stores always see the register value.
  always_comb begin
    BussA         = opnd_a;
    BussB         = ex_alu_src ? ex_imm : opnd_b;
    ex_store_data = opnd_b;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic [4:0]  id_rs, id_rt, id_wreg;
  logic [31:0] id_rdata_a, id_rdata_b, id_imm;
  logic [2:0]  id_alu_ctrl;
  logic        id_alu_src;
  logic [3:0]  id_ctrl;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_wreg, memwb_wreg;
  logic [31:0] exmem_result, memwb_result;
  logic [31:0] BussA, BussB, ex_store_data;
  logic [2:0]  ALUControl;
  logic [4:0]  ex_wreg;
  logic [3:0]  ex_ctrl;
  logic        stall;

  int checks = 0;
  int failures = 0;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .id_rs(id_rs), .id_rt(id_rt), .id_wreg(id_wreg),
    .id_rdata_a(id_rdata_a), .id_rdata_b(id_rdata_b), .id_imm(id_imm),
    .id_alu_ctrl(id_alu_ctrl), .id_alu_src(id_alu_src), .id_ctrl(id_ctrl),
    .exmem_reg_write(exmem_reg_write), .exmem_wreg(exmem_wreg), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_wreg(memwb_wreg), .memwb_result(memwb_result),
    .BussA(BussA), .BussB(BussB), .ALUControl(ALUControl),
    .ex_store_data(ex_store_data), .ex_wreg(ex_wreg), .ex_ctrl(ex_ctrl), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    id_rs = 5'd9; id_rt = 5'd10; id_wreg = 5'd11;
    id_rdata_a = 32'hDEAD0001; id_rdata_b = 32'hDEAD0002; id_imm = 32'hDEAD0003;
    id_alu_ctrl = 3'b011; id_alu_src = 1'b1; id_ctrl = 4'b1111;
    exmem_reg_write = 1'b0; exmem_wreg = 5'd0; exmem_result = 32'd0;
    memwb_reg_write = 1'b0; memwb_wreg = 5'd0; memwb_result = 32'd0;

    // Reset with busy inputs: everything reads zero
    step();
    chk("rst_bussa", BussA, 32'd0);
    chk("rst_bussb", BussB, 32'd0);
    chk("rst_aluctl", {29'd0, ALUControl}, 32'd0);
    chk("rst_store", ex_store_data, 32'd0);
    chk("rst_wreg", {27'd0, ex_wreg}, 32'd0);
    chk("rst_ctrl", {28'd0, ex_ctrl}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);

    // Plain pass-through
    rst = 1'b0;
    id_rs = 5'd1; id_rt = 5'd2; id_wreg = 5'd5;
    id_rdata_a = 32'd5; id_rdata_b = 32'd7; id_imm = 32'h100;
    id_alu_ctrl = 3'b010; id_alu_src = 1'b0; id_ctrl = 4'b1000;
    step();
    chk("pt_bussa", BussA, 32'd5);
    chk("pt_bussb", BussB, 32'd7);
    chk("pt_aluctl", {29'd0, ALUControl}, 32'd2);
    chk("pt_wreg", {27'd0, ex_wreg}, 32'd5);
    chk("pt_ctrl", {28'd0, ex_ctrl}, 32'd8);
    chk("pt_store", ex_store_data, 32'd7);

    // Immediate on operand B, store data still register B
    id_imm = 32'h10; id_rdata_b = 32'd9; id_alu_src = 1'b1; id_alu_ctrl = 3'b001;
    step();
    chk("imm_bussb", BussB, 32'h10);
    chk("imm_store", ex_store_data, 32'd9);
    chk("imm_aluctl", {29'd0, ALUControl}, 32'd1);

    // Forwarding priority on A, MEM/WB forwarding on B
    id_rs = 5'd3; id_rt = 5'd6; id_rdata_a = 32'h11; id_rdata_b = 32'h22;
    id_alu_src = 1'b0; id_alu_ctrl = 3'b000;
    exmem_reg_write = 1'b1; exmem_wreg = 5'd3; exmem_result = 32'hAAAA0000;
    memwb_reg_write = 1'b1; memwb_wreg = 5'd3; memwb_result = 32'h1234;
    step();
`ifdef FWD_EN
    chk("fwd_exmem_prio", BussA, 32'hAAAA0000);
`else
    chk("nofwd_a", BussA, 32'h11);
`endif
    chk("fwd_b_nomatch", BussB, 32'h22);
    exmem_reg_write = 1'b0;
    #1;
`ifdef FWD_EN
    chk("fwd_memwb_a", BussA, 32'h1234);
`else
    chk("nofwd_a2", BussA, 32'h11);
`endif
    memwb_wreg = 5'd6;
    #1;
`ifdef FWD_EN
    chk("fwd_memwb_b", BussB, 32'h1234);
    chk("fwd_memwb_store", ex_store_data, 32'h1234);
`else
    chk("nofwd_b", BussB, 32'h22);
    chk("nofwd_store", ex_store_data, 32'h22);
`endif
    chk("fwd_a_back", BussA, 32'h11);
    memwb_reg_write = 1'b0;

    // Register 0 is never forwarded
    id_rs = 5'd0; id_rdata_a = 32'd0;
    exmem_reg_write = 1'b1; exmem_wreg = 5'd0; exmem_result = 32'hFFFFFFFF;
    step();
    chk("zero_bussa", BussA, 32'd0);
    exmem_reg_write = 1'b0;

    // Load to r4 enters EX
    id_rs = 5'd1; id_rt = 5'd2; id_wreg = 5'd4; id_ctrl = 4'b0100;
    id_rdata_a = 32'h55; id_rdata_b = 32'h66;
    step();
    chk("ld_ctrl", {28'd0, ex_ctrl}, 32'd4);
    chk("ld_nohaz", {31'd0, stall}, 32'd0);
    id_rt = 5'd4; id_ctrl = 4'b1000; id_wreg = 5'd8;
    #1;
    chk("ld_use_stall", {31'd0, stall}, 32'd1);
    step();
    chk("bubble_ctrl", {28'd0, ex_ctrl}, 32'd0);
    chk("bubble_wreg", {27'd0, ex_wreg}, 32'd0);
    chk("bubble_bussa", BussA, 32'd0);
    chk("bubble_stall", {31'd0, stall}, 32'd0);
    step();
    chk("resume_ctrl", {28'd0, ex_ctrl}, 32'd8);
    chk("resume_bussa", BussA, 32'h55);

    // Load to r0 never stalls
    id_wreg = 5'd0; id_ctrl = 4'b0100; id_rs = 5'd0;
    step();
    chk("ld_r0_nostall", {31'd0, stall}, 32'd0);

    // Flush squashes the incoming instruction
    id_rs = 5'd1; id_rt = 5'd2; id_wreg = 5'd7; id_ctrl = 4'b1000; id_alu_ctrl = 3'b010;
    flush = 1'b1;
    step();
    chk("flush_ctrl", {28'd0, ex_ctrl}, 32'd0);
    chk("flush_wreg", {27'd0, ex_wreg}, 32'd0);
    chk("flush_aluctl", {29'd0, ALUControl}, 32'd0);
    flush = 1'b0;

    // Reset discards an instruction in flight
    step();
    chk("pre_rst_wreg", {27'd0, ex_wreg}, 32'd7);
    rst = 1'b1;
    step();
    chk("rst2_wreg", {27'd0, ex_wreg}, 32'd0);
    chk("rst2_ctrl", {28'd0, ex_ctrl}, 32'd0);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 One clock, clk; reset rst is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 flush  input  1  branch taken; squash instruction entering EX.
REQ-005 id_rs  input  5  source register A number of decode instruction.
REQ-006 id_rt  input  5  source register B number of decode instruction.
REQ-007 id_wreg  input  5  destination register number.
REQ-008 id_rdata_a  input  32  register-file read data A.
REQ-009 id_rdata_b  input  32  register-file read data B.
REQ-010 id_imm  input  32  sign-extended immediate.
REQ-011 id_alu_ctrl  input  3  ALU operation (000 add, 010 sub, 001 xor, 011 slt).
REQ-012 id_alu_src  input  1  1 = BussB takes immediate.
REQ-013 id_ctrl  input  4  {reg_write, mem_read, mem_write, mem_to_reg}.
REQ-014 exmem_reg_write, exmem_wreg, exmem_result  input  1/5/32  EX/MEM writeback candidate.
REQ-015 memwb_reg_write, memwb_wreg, memwb_result  input  1/5/32  MEM/WB writeback candidate.
REQ-016 BussA  output  32  ALU operand A.
REQ-017 BussB  output  32  ALU operand B.
REQ-018 ALUControl  output  3  registered ALU operation.
REQ-019 ex_store_data  output  32  forwarded register-B value for stores.
REQ-020 ex_wreg  output  5  registered destination; ex_ctrl  output  4  registered id_ctrl.
REQ-021 stall  output  1  load-use hazard; upstream PC and IF/ID SHALL hold while high.

Function
REQ-022 Pipeline register SHALL capture all id_* fields at each rising clk edge; latency one cycle.
REQ-023 stall SHALL be combinational: ex_ctrl mem_read=1 and ex_wreg!=0 and ex_wreg equals id_rs or id_rt.
REQ-024 On stall or flush the register SHALL load a bubble: ex_ctrl=0, ex_wreg=0, ALUControl=000, data fields 0.
REQ-025 flush and stall together: bubble loaded once; stall still reported from current state.
REQ-026 Operand A selection (FWD_EN defined): EX/MEM match first, then MEM/WB match, else registered rdata_a.
REQ-027 A match requires *_reg_write=1, *_wreg!=0, *_wreg equal to registered rs; same rule with rt for operand B.
REQ-028 BussB SHALL be id_imm (registered) when registered alu_src=1, else forwarded operand B.
REQ-029 ex_store_data SHALL be forwarded operand B regardless of alu_src.
REQ-030 Register 0 SHALL never be forwarded; BussA for rs=0 equals registered rdata_a.

Reset
REQ-031 rst at clk edge SHALL clear every register to 0 (bubble state); BussA/BussB/ALUControl/ex_ctrl/ex_wreg/ex_store_data read 0, stall 0.
REQ-032 rst SHALL override flush and stall; instruction in flight when rst asserts is discarded.

Configuration
REQ-033 Macro FWD_EN defined: forwarding per REQ-026..REQ-030.
REQ-034 FWD_EN undefined: no forwarding muxes; BussA=registered rdata_a, operand B=registered rdata_b; stall logic unchanged.

Verification
REQ-035 Reset: rst=1 one cycle with nonzero id_* -> all outputs 0 next cycle, stall=0.
REQ-036 Pass-through: id_rdata_a=5, id_rdata_b=7, alu_ctrl=010, no hazards -> next cycle BussA=5, BussB=7, ALUControl=010.
REQ-037 EX/MEM priority: rs=3, exmem_wreg=3 result=0xAAAA0000, memwb_wreg=3 result=0x1234 -> BussA=0xAAAA0000 (FWD_EN).
REQ-038 Load-use: registered mem_read=1 ex_wreg=4, id_rt=4 -> stall=1 one cycle, next cycle ex_ctrl=0.
REQ-039 Zero register: rs=0, exmem_reg_write=1 exmem_wreg=0 result=0xFFFFFFFF, rdata_a=0 -> BussA=0.
REQ-040 Flush: flush=1 with id_ctrl=1000 -> next cycle ex_ctrl=0000, ex_wreg=0.
